// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB requester: FSM state encoding, default bus widths,
// and the word-alignment helper used when a command is accepted.
package apb_master_bridge_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    function automatic logic word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB bus signals seen by the bridge.
// master = the bridge itself, slave = the command source and APB completer side.
interface apb_master_bridge_if
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles and flags the last permitted one; TIMEOUT=0 never expires.
module apb_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Turns each accepted valid/ready command into one APB transfer (or an immediate
// error for misaligned addresses) and returns a single-cycle response pulse.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_master_bridge_if.master  bus
);
    apb_state_e state;
    apb_state_e state_nxt;
    logic       expired;
    logic       accept;

    assign accept = bus.cmd_valid && (state == IDLE);

    apb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_nxt != ACCESS),
        .enable  (state == ACCESS),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && word_aligned(bus.cmd_addr[1:0])) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (bus.pready || expired) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus strobes are pure decodes of the state flops, so they change only on clock edges.
    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.psel      = (state == SETUP) || (state == ACCESS);
        bus.penable   = (state == ACCESS);
        bus.busy      = (state == SETUP) || (state == ACCESS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= {DATA_W{1'b0}};
            bus.pwrite    <= 1'b0;
            bus.paddr     <= {ADDR_W{1'b0}};
            bus.pwdata    <= {DATA_W{1'b0}};
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= {DATA_W{1'b0}};
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (word_aligned(bus.cmd_addr[1:0])) begin
                            bus.pwrite <= bus.cmd_write;
                            bus.paddr  <= bus.cmd_addr;
                            bus.pwdata <= bus.cmd_wdata;
                        end else begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // A completing pready wins over a simultaneous timeout.
                    if (bus.pready) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= bus.pwrite ? {DATA_W{1'b0}} : bus.prdata;
                    end else if (expired) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios then random commands against a
// transaction-level model, with a responsive APB completer holding its own memory.
module tb_apb_master_bridge;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          wait_n;
        int          psel_n;
        int          pen_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q[$];
    exp_t        head;
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];
    int          checks = 0;
    int          passed = 0;
    int          psel_seen = 0;
    int          pen_seen = 0;
    int          acc_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Transaction-level prediction: outcome, read data and bus-cycle counts per command.
    function automatic exp_t predict(input logic wr, input logic [31:0] addr,
                                     input logic [31:0] wdata, input int w);
        exp_t e;
        int   acc;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.wait_n = w; e.rdata = '0;
        if (addr[1:0] != 2'b00) begin
            e.err = 1'b1; e.psel_n = 0; e.pen_n = 0;
        end else begin
            acc      = (w < TIMEOUT) ? w + 1 : TIMEOUT;
            e.err    = (w >= TIMEOUT);
            e.pen_n  = acc;
            e.psel_n = acc + 1;
            if (!e.err) begin
                if (wr) model_mem[addr] = wdata;
                else if (model_mem.exists(addr)) e.rdata = model_mem[addr];
            end
        end
        return e;
    endfunction

    // Monitor first, then the APB completer, evaluated away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            psel_seen = 0; pen_seen = 0; acc_seen = 0;
            bus.pready = 1'b0;
        end else begin
            if (bus.psel) psel_seen++;
            if (bus.penable) pen_seen++;
            if (bus.penable && !bus.psel) check("penable_wo_psel", 1, 0);
            if (bus.psel) begin
                check("busy_ready", {bus.busy, bus.cmd_ready}, 2'b10);
                if (exp_q.size() > 0) begin
                    check("paddr", bus.paddr, exp_q[0].addr);
                    check("pwrite", bus.pwrite, exp_q[0].wr);
                    if (exp_q[0].wr) check("pwdata", bus.pwdata, exp_q[0].wdata);
                end
            end
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_extra", 1, 0);
                end else begin
                    head = exp_q.pop_front();
                    check("rsp_err", bus.rsp_err, head.err);
                    check("rsp_rdata", bus.rsp_rdata, head.rdata);
                    check("psel_cycles", psel_seen, head.psel_n);
                    check("penable_cycles", pen_seen, head.pen_n);
                end
                psel_seen = 0; pen_seen = 0;
            end
            if (bus.psel && bus.penable) begin
                acc_seen++;
                if (exp_q.size() > 0 && acc_seen == exp_q[0].wait_n + 1) begin
                    bus.pready = 1'b1;
                    if (bus.pwrite) slave_mem[bus.paddr] = bus.pwdata;
                    bus.prdata = slave_mem.exists(bus.paddr) ? slave_mem[bus.paddr] : '0;
                end else begin
                    bus.pready = 1'b0;
                    bus.prdata = $urandom;
                end
            end else begin
                acc_seen   = 0;
                bus.pready = 1'($urandom_range(0, 1));
                bus.prdata = $urandom;
            end
        end
    end

    // Called at negedge+1; returns at negedge+1 after the accepting edge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int w, input bit hold, output int waited);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        waited = 0;
        while (!bus.cmd_ready && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!bus.cmd_ready) check("accept_timeout", 0, 1);
        else exp_q.push_back(predict(wr, addr, wdata, w));
        @(negedge clk); #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk); #1;
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] a;
        logic        wr;
        int          w;
        bit          hold;

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.pready = 1'b0; bus.prdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_psel", bus.psel, 0);
        check("rst_penable", bus.penable, 0);
        check("rst_pwrite", bus.pwrite, 0);
        check("rst_paddr", bus.paddr, 0);
        check("rst_pwdata", bus.pwdata, 0);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.busy}, 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        #1 rst = 1'b0;

        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1'b0, n);
        drain();
        send(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, n);
        drain();
        send(1'b0, 32'h0000_0010, 32'h0, 99, 1'b0, n);
        drain();
        send(1'b0, 32'h0000_0013, 32'h0, 0, 1'b0, n);
        drain();

        // Reset while a transfer is stuck in ACCESS.
        send(1'b0, 32'h0000_0040, 32'h0, 99, 1'b0, n);
        repeat (3) begin @(negedge clk); #1; end
        check("pre_rst_penable", bus.penable, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_bus", {bus.psel, bus.penable}, 2'b00);
        check("mid_rst_rsp", bus.rsp_valid, 0);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_ready", bus.cmd_ready, 1);
        check("post_rst_rsp", bus.rsp_valid, 0);
        #1;

        send(1'b1, 32'h0000_0020, 32'h0000_1111, 0, 1'b1, n);
        send(1'b1, 32'h0000_0024, 32'h0000_2222, 0, 1'b0, n);
        check("b2b_gap", n, 2);
        drain();
        send(1'b0, 32'h0000_0024, 32'h0, 2, 1'b0, n);
        drain();

        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            w    = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0);
            send(wr, a, $urandom, w, hold, n);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
            end
        end
        bus.cmd_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
